// File: rtl/aes_share.sv
// Round-robin arbiter sharing one iterative aes core among N_REQ requesters.
// Grants one block per turn, drives start/init and returns the result or a watchdog abort.
module aes_share #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          resp_valid,
  output logic                      resp_err,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      aes_start,
  output logic [DATA_W-1:0]         aes_state_init,
  input  logic                      aes_done,
  input  logic [DATA_W-1:0]         aes_state_final,
  input  logic                      err_clr,
  output logic                      err_sticky
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               aes_start_q, aes_start_d;
  logic [DATA_W-1:0]  aes_state_init_q, aes_state_init_d;
  logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;
  logic               err_sticky_q, err_sticky_d;

  logic [PTR_W-1:0]   pick;
  logic               pick_vld;
  logic [PTR_W-1:0]   ptr_next;
  logic [DATA_W-1:0]  lanes [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lanes[i] = req_data[i*DATA_W +: DATA_W];
  end

  // First pending requester at or after ptr, wrapping.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] idx_p;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    idx_p    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx   = (int'(ptr_q) + k) % N_REQ;
      idx_p = PTR_W'(idx);
      if (!pick_vld && req_valid[idx_p]) begin
        pick_vld = 1'b1;
        pick     = idx_p;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && pick_vld) req_ready[pick] = 1'b1;
  end

  assign ptr_next = (gnt_q == PTR_LAST) ? '0 : gnt_q + 1'b1;

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    gnt_d            = gnt_q;
    cnt_d            = cnt_q;
    aes_start_d      = 1'b0;
    aes_state_init_d = aes_state_init_q;
    resp_valid_d     = '0;
    resp_err_d       = resp_err_q;
    resp_data_d      = resp_data_q;
    err_sticky_d     = err_clr ? 1'b0 : err_sticky_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d            = pick;
          aes_state_init_d = lanes[pick];
          aes_start_d      = 1'b1;
          state_d          = START;
        end
      end
      START: begin
        // The counter includes the START cycle, so an abort surfaces TIMEOUT cycles after it.
        cnt_d   = CNT_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (aes_done) begin
          resp_data_d         = aes_state_final;
          resp_valid_d[gnt_q] = 1'b1;
          resp_err_d          = 1'b0;
          ptr_d               = ptr_next;
          state_d             = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          resp_data_d         = '0;
          resp_valid_d[gnt_q] = 1'b1;
          resp_err_d          = 1'b1;
          err_sticky_d        = 1'b1;
          ptr_d               = ptr_next;
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      ptr_q            <= '0;
      gnt_q            <= '0;
      cnt_q            <= '0;
      aes_start_q      <= 1'b0;
      aes_state_init_q <= '0;
      resp_valid_q     <= '0;
      resp_err_q       <= 1'b0;
      resp_data_q      <= '0;
      err_sticky_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      gnt_q            <= gnt_d;
      cnt_q            <= cnt_d;
      aes_start_q      <= aes_start_d;
      aes_state_init_q <= aes_state_init_d;
      resp_valid_q     <= resp_valid_d;
      resp_err_q       <= resp_err_d;
      resp_data_q      <= resp_data_d;
      err_sticky_q     <= err_sticky_d;
    end
  end

  assign aes_start      = aes_start_q;
  assign aes_state_init = aes_state_init_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_data      = resp_data_q;
  assign err_sticky     = err_sticky_q;

endmodule
